// File: rtl/dma_sequencer_if.sv
// Bus/handshake bundle between the DMA sequencer and the glue/datapath side.
// The master modport is the sequencer (it owns DMA); slave is the glue side.
interface dma_sequencer_if #(
  parameter int RA_W  = 24,
  parameter int LEN_W = 16
);
  logic             execute_i;
  logic             ba_i;
  logic [1:0]       cmd_type_i;
  logic             cmd_autoload_i;
  logic [1:0]       addr_fix_i;
  logic [15:0]      c64_base_i;
  logic [RA_W-1:0]  ram_base_i;
  logic [LEN_W-1:0] len_base_i;
  logic             verify_err_i;

  logic             dma_o;
  logic             dmarw_o;
  logic [15:0]      ca_o;
  logic [RA_W-1:0]  ra_o;
  logic [LEN_W-1:0] len_o;
  logic             ram_we_o;
  logic             data_latch_o;
  logic             busy_o;
  logic             eob_o;
  logic             fault_o;

  modport master (
    input  execute_i, ba_i, cmd_type_i, cmd_autoload_i, addr_fix_i,
           c64_base_i, ram_base_i, len_base_i, verify_err_i,
    output dma_o, dmarw_o, ca_o, ra_o, len_o, ram_we_o, data_latch_o,
           busy_o, eob_o, fault_o
  );

  modport slave (
    output execute_i, ba_i, cmd_type_i, cmd_autoload_i, addr_fix_i,
           c64_base_i, ram_base_i, len_base_i, verify_err_i,
    input  dma_o, dmarw_o, ca_o, ra_o, len_o, ram_we_o, data_latch_o,
           busy_o, eob_o, fault_o
  );
endinterface

// File: rtl/dma_sequencer.sv
// DMA sequencer: walks C64/RAM address and length counters after Execute,
// decoding bus direction and RAM/latch strobes per state, with EOB/Fault pulses.
module dma_sequencer #(
  parameter int RA_W  = 24,
  parameter int LEN_W = 16
) (
  input  logic           phi2_i,
  input  logic           nreset_i,
  dma_sequencer_if.master bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_XFER   = 2'd1;
  localparam logic [1:0] ST_SWAP_A = 2'd2;
  localparam logic [1:0] ST_SWAP_B = 2'd3;

  localparam logic [1:0] CMD_STASH  = 2'd0;
  localparam logic [1:0] CMD_FETCH  = 2'd1;
  localparam logic [1:0] CMD_SWAP   = 2'd2;
  localparam logic [1:0] CMD_VERIFY = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [1:0]       fix_q, fix_d;
  logic             autoload_q, autoload_d;
  logic [15:0]      ca_q, ca_d;
  logic [RA_W-1:0]  ra_q, ra_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             eob_q, eob_d;
  logic             fault_q, fault_d;

  logic [15:0]      ca_inc;
  logic [RA_W-1:0]  ra_inc;
  logic             last_byte;
  logic             mismatch;

  assign ca_inc    = fix_q[1] ? ca_q : ca_q + 16'd1;
  assign ra_inc    = fix_q[0] ? ra_q : ra_q + RA_W'(1);
  assign last_byte = (len_q == LEN_W'(1));
  assign mismatch  = (state_q == ST_XFER) && (cmd_q == CMD_VERIFY) && bus.verify_err_i;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    fix_d      = fix_q;
    autoload_d = autoload_q;
    ca_d       = ca_q;
    ra_d       = ra_q;
    len_d      = len_q;
    eob_d      = 1'b0;
    fault_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.execute_i) begin
          cmd_d      = bus.cmd_type_i;
          fix_d      = bus.addr_fix_i;
          autoload_d = bus.cmd_autoload_i;
          ca_d       = bus.c64_base_i;
          ra_d       = bus.ram_base_i;
          len_d      = bus.len_base_i;
          state_d    = (bus.cmd_type_i == CMD_SWAP) ? ST_SWAP_A : ST_XFER;
        end
      end
      ST_SWAP_A: begin
        if (bus.ba_i) begin
          state_d = ST_SWAP_B;
        end
      end
      ST_XFER, ST_SWAP_B: begin
        if (bus.ba_i) begin
          // Autoload only rewinds on a genuine end of block; a verify abort
          // leaves the counters pointing just past the offending byte.
          if (last_byte && autoload_q) begin
            ca_d  = bus.c64_base_i;
            ra_d  = bus.ram_base_i;
            len_d = bus.len_base_i;
          end else begin
            ca_d = ca_inc;
            ra_d = ra_inc;
            if (!last_byte) begin
              len_d = len_q - LEN_W'(1);
            end
          end

          if (last_byte || mismatch) begin
            state_d = ST_IDLE;
            eob_d   = last_byte;
            fault_d = mismatch;
          end else begin
            state_d = (state_q == ST_SWAP_B) ? ST_SWAP_A : ST_XFER;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge phi2_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_STASH;
      fix_q      <= 2'b00;
      autoload_q <= 1'b0;
      ca_q       <= '0;
      ra_q       <= '0;
      len_q      <= '0;
      eob_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      fix_q      <= fix_d;
      autoload_q <= autoload_d;
      ca_q       <= ca_d;
      ra_q       <= ra_d;
      len_q      <= len_d;
      eob_q      <= eob_d;
      fault_q    <= fault_d;
    end
  end

  // Strobes describe the pending bus cycle and stay decoded through BA stalls.
  logic dmarw_c, ram_we_c, data_latch_c;

  always_comb begin
    dmarw_c      = 1'b1;
    ram_we_c     = 1'b0;
    data_latch_c = 1'b0;
    case (state_q)
      ST_XFER: begin
        dmarw_c  = (cmd_q != CMD_FETCH);
        ram_we_c = (cmd_q == CMD_STASH);
      end
      ST_SWAP_A: begin
        data_latch_c = 1'b1;
      end
      ST_SWAP_B: begin
        dmarw_c  = 1'b0;
        ram_we_c = 1'b1;
      end
      default: begin
        dmarw_c = 1'b1;
      end
    endcase
  end

  assign bus.dma_o        = (state_q != ST_IDLE);
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.dmarw_o      = dmarw_c;
  assign bus.ram_we_o     = ram_we_c;
  assign bus.data_latch_o = data_latch_c;
  assign bus.ca_o         = ca_q;
  assign bus.ra_o         = ra_q;
  assign bus.len_o        = len_q;
  assign bus.eob_o        = eob_q;
  assign bus.fault_o      = fault_q;

endmodule

// File: tb/tb_dma_sequencer.sv
// Directed bench for dma_sequencer: expected bus beats are queued per command
// and popped as the sequencer completes each BA-qualified bus cycle.
module tb_dma_sequencer;

  typedef struct packed {
    logic        dmarw;
    logic        ram_we;
    logic        latch;
    logic [15:0] ca;
    logic [23:0] ra;
    logic [15:0] len;
  } beat_t;

  logic phi2;
  logic nreset;
  int   checks;
  int   errors;
  beat_t exp_q[$];

  dma_sequencer_if #(.RA_W(24), .LEN_W(16)) bus ();

  dma_sequencer #(.RA_W(24), .LEN_W(16)) dut (
    .phi2_i  (phi2),
    .nreset_i(nreset),
    .bus     (bus)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  task automatic step();
    @(posedge phi2);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.dmarw  = bus.dmarw_o;
    b.ram_we = bus.ram_we_o;
    b.latch  = bus.data_latch_o;
    b.ca     = bus.ca_o;
    b.ra     = bus.ra_o;
    b.len    = bus.len_o;
    return b;
  endfunction

  function automatic beat_t mk(input logic rw, input logic we, input logic dl,
                               input logic [15:0] ca, input logic [23:0] ra,
                               input logic [15:0] len);
    beat_t b;
    b.dmarw = rw; b.ram_we = we; b.latch = dl;
    b.ca = ca; b.ra = ra; b.len = len;
    return b;
  endfunction

  task automatic run(input string name, input logic [1:0] cmd, input logic al,
                     input logic [1:0] fix, input logic [15:0] cb,
                     input logic [23:0] rb, input logic [15:0] lb,
                     input int stall_at, input int stall_len,
                     input int err_byte, input bit dup_exec);
    int n, nb, per, cyc, popped;
    logic exp_eob, exp_fault;
    logic [15:0] eca, elen;
    logic [23:0] era;
    beat_t b;

    n         = (lb == 16'd0) ? 65536 : int'(lb);
    exp_fault = (cmd == 2'd3) && (err_byte >= 0) && (err_byte < n);
    nb        = exp_fault ? err_byte + 1 : n;
    exp_eob   = (nb == n);
    per       = (cmd == 2'd2) ? 2 : 1;

    for (int k = 0; k < nb; k++) begin
      eca  = cb + (fix[1] ? 16'd0 : 16'(k));
      era  = rb + (fix[0] ? 24'd0 : 24'(k));
      elen = lb - 16'(k);
      case (cmd)
        2'd0: exp_q.push_back(mk(1'b1, 1'b1, 1'b0, eca, era, elen));
        2'd1: exp_q.push_back(mk(1'b0, 1'b0, 1'b0, eca, era, elen));
        2'd2: begin
          exp_q.push_back(mk(1'b1, 1'b0, 1'b1, eca, era, elen));
          exp_q.push_back(mk(1'b0, 1'b1, 1'b0, eca, era, elen));
        end
        default: exp_q.push_back(mk(1'b1, 1'b0, 1'b0, eca, era, elen));
      endcase
    end

    bus.cmd_type_i     = cmd;
    bus.cmd_autoload_i = al;
    bus.addr_fix_i     = fix;
    bus.c64_base_i     = cb;
    bus.ram_base_i     = rb;
    bus.len_base_i     = lb;
    bus.ba_i           = 1'b1;
    bus.execute_i      = 1'b1;
    step();
    bus.execute_i = 1'b0;
    check({name, " start dma/busy"}, 64'({bus.dma_o, bus.busy_o}), 64'(2'b11));

    cyc = 0;
    popped = 0;
    while (bus.dma_o && cyc < 3 * n + 20) begin
      bus.ba_i      = !(cyc >= stall_at && cyc < stall_at + stall_len);
      bus.execute_i = dup_exec && (cyc == 1);
      bus.cmd_type_i = (dup_exec && cyc == 1) ? 2'd0 : cmd;
      if (exp_q.size() == 0) begin
        check({name, " beat overrun"}, 64'(1), 64'(0));
        break;
      end
      b = cur_beat();
      check({name, bus.ba_i ? " beat" : " stall beat"}, 64'(b), 64'(exp_q[0]));
      bus.verify_err_i = bus.ba_i && (cmd == 2'd3) && ((popped / per) == err_byte);
      if (bus.ba_i) begin
        void'(exp_q.pop_front());
        popped++;
      end
      step();
      cyc++;
    end
    bus.ba_i         = 1'b1;
    bus.execute_i    = 1'b0;
    bus.verify_err_i = 1'b0;
    bus.cmd_type_i   = cmd;

    if (exp_eob && al) begin
      eca = cb; era = rb; elen = lb;
    end else begin
      eca  = cb + (fix[1] ? 16'd0 : 16'(nb));
      era  = rb + (fix[0] ? 24'd0 : 24'(nb));
      elen = exp_eob ? 16'd1 : lb - 16'(nb);
    end
    check({name, " end dma/busy"}, 64'({bus.dma_o, bus.busy_o}), 64'(2'b00));
    check({name, " queue drained"}, 64'(exp_q.size()), 64'(0));
    check({name, " eob/fault pulse"}, 64'({bus.eob_o, bus.fault_o}), 64'({exp_eob, exp_fault}));
    check({name, " end counters"}, 64'({bus.ca_o, bus.ra_o, bus.len_o}), 64'({eca, era, elen}));
    step();
    check({name, " pulse cleared"}, 64'({bus.eob_o, bus.fault_o}), 64'(2'b00));
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nreset = 1'b0;
    bus.execute_i      = 1'b0;
    bus.ba_i           = 1'b1;
    bus.cmd_type_i     = 2'd0;
    bus.cmd_autoload_i = 1'b0;
    bus.addr_fix_i     = 2'b00;
    bus.c64_base_i     = 16'h0;
    bus.ram_base_i     = 24'h0;
    bus.len_base_i     = 16'h0;
    bus.verify_err_i   = 1'b0;
    #3;
    check("reset outputs",
          64'({bus.dma_o, bus.dmarw_o, bus.ram_we_o, bus.data_latch_o,
               bus.busy_o, bus.eob_o, bus.fault_o}), 64'(7'b0100000));
    check("reset counters", 64'({bus.ca_o, bus.ra_o, bus.len_o}), 64'(0));
    @(negedge phi2);
    nreset = 1'b1;
    step();
    check("idle after reset", 64'({bus.dma_o, bus.busy_o}), 64'(2'b00));

    run("stash",    2'd0, 1'b0, 2'b00, 16'hC000, 24'h000100, 16'd3, -1, 0, -1, 1'b0);
    run("fetch",    2'd1, 1'b0, 2'b00, 16'h2000, 24'h000040, 16'd4,  2, 2, -1, 1'b1);
    run("swap",     2'd2, 1'b0, 2'b10, 16'hD000, 24'h000200, 16'd2,  1, 1, -1, 1'b0);
    run("verify",   2'd3, 1'b0, 2'b00, 16'h1000, 24'h000300, 16'd5, -1, 0,  1, 1'b0);
    run("verlast",  2'd3, 1'b0, 2'b01, 16'h1100, 24'h000310, 16'd3, -1, 0,  2, 1'b0);
    run("autoload", 2'd0, 1'b1, 2'b00, 16'h4000, 24'hFFFFFF, 16'd2, -1, 0, -1, 1'b0);
    run("len64k",   2'd1, 1'b0, 2'b00, 16'h0000, 24'h000000, 16'd0, -1, 0, -1, 1'b0);

    bus.cmd_type_i = 2'd0;
    bus.c64_base_i = 16'h8000;
    bus.ram_base_i = 24'h000500;
    bus.len_base_i = 16'd10;
    bus.execute_i  = 1'b1;
    step();
    bus.execute_i = 1'b0;
    step();
    step();
    check("pre-reset busy", 64'({bus.dma_o, bus.busy_o, bus.ca_o}), 64'({2'b11, 16'h8002}));
    #2;
    nreset = 1'b0;
    #1;
    check("async reset drop", 64'({bus.dma_o, bus.busy_o, bus.ram_we_o}), 64'(3'b000));
    check("async reset counters", 64'({bus.ca_o, bus.ra_o, bus.len_o}), 64'(0));
    @(negedge phi2);
    nreset = 1'b1;
    step();
    check("idle after reset release", 64'({bus.dma_o, bus.busy_o}), 64'(2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
